// File: rtl/gpr_mp_if.sv
// Request/response bundle between the ID/WB pipeline stages (master) and the gpr_mp register file (slave).
interface gpr_mp_if #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5,
    parameter int NRP    = 2
);
    logic [NRP-1:0]        rd_re_i;
    logic [NRP*REG_AW-1:0] rd_addr_i;
    logic [NRP*XLEN-1:0]   rd_data_o;
    logic [NRP-1:0]        rd_busy_o;
    logic                  wa_we_i;
    logic [REG_AW-1:0]     wa_addr_i;
    logic [XLEN-1:0]       wa_data_i;
    logic                  wb_we_i;
    logic [REG_AW-1:0]     wb_addr_i;
    logic [XLEN-1:0]       wb_data_i;
    logic                  alloc_we_i;
    logic [REG_AW-1:0]     alloc_addr_i;
    logic                  ready_o;

    modport master (
        output rd_re_i, rd_addr_i,
        output wa_we_i, wa_addr_i, wa_data_i,
        output wb_we_i, wb_addr_i, wb_data_i,
        output alloc_we_i, alloc_addr_i,
        input  rd_data_o, rd_busy_o, ready_o
    );

    modport slave (
        input  rd_re_i, rd_addr_i,
        input  wa_we_i, wa_addr_i, wa_data_i,
        input  wb_we_i, wb_addr_i, wb_data_i,
        input  alloc_we_i, alloc_addr_i,
        output rd_data_o, rd_busy_o, ready_o
    );
endinterface

// File: rtl/gpr_mp.sv
// Multi-port GPR file with two prioritised write ports, busy scoreboard and post-reset clear sequencer.
// Optional macro GPR_BYPASS_EN enables same-cycle write-to-read forwarding.
module gpr_mp #(
    parameter int XLEN    = 32,
    parameter int REG_NUM = 32,
    parameter int REG_AW  = 5,
    parameter int NRP     = 2
) (
    input logic     clk_i,
    input logic     rst_i,
    gpr_mp_if.slave bus
);
    typedef enum logic {S_CLEAR, S_RUN} state_t;

    state_t              state_q, state_d;
    logic [REG_AW-1:0]   cnt_q, cnt_d;
    logic                clr_we;
    logic                run;
    logic [XLEN-1:0]     regs [REG_NUM];
    logic [REG_NUM-1:0]  busy_q;
    logic [REG_AW-1:0]   ra [NRP];
    logic [NRP*XLEN-1:0] rd_data;
    logic [NRP-1:0]      rd_busy;

    // Register 0 is hardwired: no port ever hits it.
    function automatic logic hit(input logic we, input logic [REG_AW-1:0] a,
                                 input logic [REG_AW-1:0] r);
        return we && (a == r) && (r != '0);
    endfunction

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_CLEAR;
            cnt_q   <= REG_AW'(1);
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        clr_we  = 1'b0;
        run     = 1'b0;
        case (state_q)
            S_CLEAR: begin
                clr_we = 1'b1;
                cnt_d  = cnt_q + REG_AW'(1);
                if (cnt_q == REG_AW'(REG_NUM - 1))
                    state_d = S_RUN;
            end
            S_RUN: run = !rst_i;
            default: state_d = S_CLEAR;
        endcase
    end

    assign bus.ready_o = (state_q == S_RUN);

    // Data storage carries no reset; the clear sequencer zeroes it instead.
    always_ff @(posedge clk_i) begin
        for (int r = 1; r < REG_NUM; r++) begin
            if (clr_we && cnt_q == REG_AW'(r))
                regs[r] <= '0;
            else if (run && hit(bus.wb_we_i, bus.wb_addr_i, REG_AW'(r)))
                regs[r] <= bus.wb_data_i;
            else if (run && hit(bus.wa_we_i, bus.wa_addr_i, REG_AW'(r)))
                regs[r] <= bus.wa_data_i;
        end
    end

    // A new allocation supersedes a completing write to the same register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            busy_q <= '0;
        end else if (run) begin
            for (int r = 1; r < REG_NUM; r++) begin
                if (hit(bus.alloc_we_i, bus.alloc_addr_i, REG_AW'(r)))
                    busy_q[r] <= 1'b1;
                else if (hit(bus.wa_we_i, bus.wa_addr_i, REG_AW'(r)) ||
                         hit(bus.wb_we_i, bus.wb_addr_i, REG_AW'(r)))
                    busy_q[r] <= 1'b0;
            end
        end
    end

    always_comb begin
        for (int k = 0; k < NRP; k++)
            ra[k] = bus.rd_addr_i[k*REG_AW +: REG_AW];
    end

    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        for (int k = 0; k < NRP; k++) begin
            if (bus.ready_o && bus.rd_re_i[k] && ra[k] != '0) begin
                rd_data[k*XLEN +: XLEN] = regs[ra[k]];
                rd_busy[k]              = busy_q[ra[k]];
`ifdef GPR_BYPASS_EN
                // Port B is the younger write, so it wins the forward.
                if (hit(bus.wb_we_i, bus.wb_addr_i, ra[k])) begin
                    rd_data[k*XLEN +: XLEN] = bus.wb_data_i;
                    rd_busy[k]              = hit(bus.alloc_we_i, bus.alloc_addr_i, ra[k]);
                end else if (hit(bus.wa_we_i, bus.wa_addr_i, ra[k])) begin
                    rd_data[k*XLEN +: XLEN] = bus.wa_data_i;
                    rd_busy[k]              = hit(bus.alloc_we_i, bus.alloc_addr_i, ra[k]);
                end
`endif
            end
        end
    end

    assign bus.rd_data_o = rd_data;
    assign bus.rd_busy_o = rd_busy;
endmodule

// File: tb/tb_gpr_mp.sv
// Directed self-checking bench for gpr_mp: clear sequence, writes, priority, scoreboard, reset, multi-port reads.
module tb_gpr_mp;
    localparam int XLEN = 32;
    localparam int REG_NUM = 32;
    localparam int REG_AW = 5;
    localparam int NRP = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int errors = 0;
    int checks = 0;
    int n;

    always #5 clk = ~clk;

    gpr_mp_if #(.XLEN(XLEN), .REG_AW(REG_AW), .NRP(NRP)) bus ();

    gpr_mp #(.XLEN(XLEN), .REG_NUM(REG_NUM), .REG_AW(REG_AW), .NRP(NRP)) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus.slave)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.wa_we_i = 1'b0;  bus.wa_addr_i = '0;  bus.wa_data_i = '0;
        bus.wb_we_i = 1'b0;  bus.wb_addr_i = '0;  bus.wb_data_i = '0;
        bus.alloc_we_i = 1'b0; bus.alloc_addr_i = '0;
    endtask

    task automatic rd(input int p, input logic re, input logic [REG_AW-1:0] a);
        bus.rd_re_i[p] = re;
        bus.rd_addr_i[p*REG_AW +: REG_AW] = a;
    endtask

    function automatic logic [31:0] dat(input int p);
        return bus.rd_data_o[p*XLEN +: XLEN];
    endfunction

    task automatic wait_ready(input string tag);
        n = 0;
        while (!bus.ready_o && n < 40) begin
            cyc();
            n++;
        end
        check(tag, n, 31);
    endtask

    initial begin
        idle();
        bus.rd_re_i = '0;
        bus.rd_addr_i = '0;
        cyc();
        rst = 1'b0;
        rd(0, 1'b1, 5'd9);
        #1;
        check("reset_ready", {31'd0, bus.ready_o}, 0);
        check("reset_busy", {31'd0, bus.rd_busy_o[0]}, 0);
        wait_ready("clear_cycles");
        check("ready_high", {31'd0, bus.ready_o}, 1);

        for (int r = 1; r < REG_NUM; r++) begin
            rd(0, 1'b1, REG_AW'(r));
            #1;
            check("cleared_reg", dat(0), 32'h0);
        end

        // x5 write, with same-cycle read
        bus.wa_we_i = 1'b1; bus.wa_addr_i = 5'd5; bus.wa_data_i = 32'hDEADBEEF;
        rd(0, 1'b1, 5'd5);
        #1;
`ifdef GPR_BYPASS_EN
        check("x5_same_cycle", dat(0), 32'hDEADBEEF);
`else
        check("x5_same_cycle", dat(0), 32'h0);
`endif
        cyc(); idle(); #1;
        check("x5_read", dat(0), 32'hDEADBEEF);

        // x0 is never written
        bus.wa_we_i = 1'b1; bus.wa_addr_i = 5'd0; bus.wa_data_i = 32'h1234;
        bus.alloc_we_i = 1'b1; bus.alloc_addr_i = 5'd0;
        cyc(); idle(); rd(0, 1'b1, 5'd0); #1;
        check("x0_data", dat(0), 32'h0);
        check("x0_busy", {31'd0, bus.rd_busy_o[0]}, 0);

        // wa and wb collide on x7
        bus.wa_we_i = 1'b1; bus.wa_addr_i = 5'd7; bus.wa_data_i = 32'h11;
        bus.wb_we_i = 1'b1; bus.wb_addr_i = 5'd7; bus.wb_data_i = 32'h22;
        rd(0, 1'b1, 5'd7);
        #1;
`ifdef GPR_BYPASS_EN
        check("x7_same_cycle", dat(0), 32'h22);
`else
        check("x7_same_cycle", dat(0), 32'h0);
`endif
        cyc(); idle(); #1;
        check("x7_priority", dat(0), 32'h22);

        // independent writes on both ports
        bus.wa_we_i = 1'b1; bus.wa_addr_i = 5'd10; bus.wa_data_i = 32'h100;
        bus.wb_we_i = 1'b1; bus.wb_addr_i = 5'd11; bus.wb_data_i = 32'h200;
        cyc(); idle();
        rd(0, 1'b1, 5'd10); rd(1, 1'b1, 5'd11); #1;
        check("x10_wa", dat(0), 32'h100);
        check("x11_wb", dat(1), 32'h200);

        // scoreboard on x9
        rd(0, 1'b1, 5'd9); rd(1, 1'b0, 5'd0);
        bus.alloc_we_i = 1'b1; bus.alloc_addr_i = 5'd9;
        #1;
        check("x9_pre_alloc", {31'd0, bus.rd_busy_o[0]}, 0);
        cyc(); idle(); #1;
        check("x9_alloc", {31'd0, bus.rd_busy_o[0]}, 1);
        bus.wa_we_i = 1'b1; bus.wa_addr_i = 5'd9; bus.wa_data_i = 32'h55;
        bus.alloc_we_i = 1'b1; bus.alloc_addr_i = 5'd9;
        #1;
        check("x9_wr_alloc_same", {31'd0, bus.rd_busy_o[0]}, 1);
        cyc(); idle(); #1;
        check("x9_set_wins", {31'd0, bus.rd_busy_o[0]}, 1);
        bus.wb_we_i = 1'b1; bus.wb_addr_i = 5'd9; bus.wb_data_i = 32'h99;
        #1;
`ifdef GPR_BYPASS_EN
        check("x9_wr_same", {31'd0, bus.rd_busy_o[0]}, 0);
`else
        check("x9_wr_same", {31'd0, bus.rd_busy_o[0]}, 1);
`endif
        cyc(); idle(); #1;
        check("x9_cleared", {31'd0, bus.rd_busy_o[0]}, 0);
        check("x9_data", dat(0), 32'h99);

        // write to a non-busy register leaves it idle
        bus.wa_we_i = 1'b1; bus.wa_addr_i = 5'd12; bus.wa_data_i = 32'hC0FFEE;
        rd(0, 1'b1, 5'd12);
        cyc(); idle(); #1;
        check("x12_data", dat(0), 32'hC0FFEE);
        check("x12_busy", {31'd0, bus.rd_busy_o[0]}, 0);

        // x1 / x2 setup, x2 left busy, then 3-port read with port 1 disabled
        bus.wa_we_i = 1'b1; bus.wa_addr_i = 5'd1; bus.wa_data_i = 32'h5A5A;
        bus.wb_we_i = 1'b1; bus.wb_addr_i = 5'd2; bus.wb_data_i = 32'h77;
        bus.alloc_we_i = 1'b1; bus.alloc_addr_i = 5'd2;
        cyc(); idle();
        rd(0, 1'b1, 5'd1); rd(1, 1'b1, 5'd2); rd(2, 1'b1, 5'd1); #1;
        check("x2_busy_en", {31'd0, bus.rd_busy_o[1]}, 1);
        check("x2_data_en", dat(1), 32'h77);
        rd(1, 1'b0, 5'd2); #1;
        check("p0_x1", dat(0), 32'h5A5A);
        check("p1_off_data", dat(1), 32'h0);
        check("p1_off_busy", {31'd0, bus.rd_busy_o[1]}, 0);
        check("p2_x1", dat(2), 32'h5A5A);

        // reset in RUN, with requests attempted during the clear
        bus.rd_re_i = '0;
        bus.wa_we_i = 1'b1; bus.wa_addr_i = 5'd3; bus.wa_data_i = 32'hAA;
        cyc(); idle(); rd(0, 1'b1, 5'd3); #1;
        check("x3_before_rst", dat(0), 32'hAA);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        #1;
        check("rst2_ready", {31'd0, bus.ready_o}, 0);
        check("rst2_forced0", dat(0), 32'h0);
        bus.wa_we_i = 1'b1; bus.wa_addr_i = 5'd1; bus.wa_data_i = 32'hBAD;
        bus.alloc_we_i = 1'b1; bus.alloc_addr_i = 5'd21;
        wait_ready("clear_cycles_2");
        idle();
        rd(0, 1'b1, 5'd3); rd(1, 1'b1, 5'd2); rd(2, 1'b1, 5'd1); #1;
        check("x3_after_rst", dat(0), 32'h0);
        check("x2_busy_rst", {31'd0, bus.rd_busy_o[1]}, 0);
        check("x1_clear_ignored", dat(2), 32'h0);
        rd(0, 1'b1, 5'd21); #1;
        check("x21_alloc_ignored", {31'd0, bus.rd_busy_o[0]}, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/gpr_mp.md
Name: gpr_mp

Overview:
- Parametrised multi-port general purpose register file for the core's ID/WB stages.
- Successor of the 2-read/1-write GPR: configurable data width, register count and read-port count, and two write ports with defined priority.
- Adds a per-register busy scoreboard for hazard detection.
- Adds a hardware clear sequencer that zeroes every register after reset and reports readiness to the pipeline.

Parameters:
- XLEN, 32, data width of each register
- REG_NUM, 32, number of architectural registers (power of two, >= 4)
- REG_AW, 5, address width; must equal log2(REG_NUM)
- NRP, 2, number of read ports (1..4)

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- rd_re_i  in  NRP  per-port read enable
- rd_addr_i  in  NRP*REG_AW  read addresses; port k occupies bits [k*REG_AW +: REG_AW]
- rd_data_o  out  NRP*XLEN  read data, same packing
- rd_busy_o  out  NRP  busy flag of the addressed register, per port
- wa_we_i  in  1  write port A enable (older instruction)
- wa_addr_i  in  REG_AW  write port A address
- wa_data_i  in  XLEN  write port A data
- wb_we_i  in  1  write port B enable (younger instruction)
- wb_addr_i  in  REG_AW  write port B address
- wb_data_i  in  XLEN  write port B data
- alloc_we_i  in  1  issue-time allocation: mark destination busy
- alloc_addr_i  in  REG_AW  destination being allocated
- ready_o  out  1  clear sequence finished; file usable

Behaviour:
- Reset: rst_i sampled on clk_i rising edge.
  - Busy bits all 0.
  - FSM enters CLEAR with clear counter = 1.
  - ready_o = 0.
  - Read outputs combinational; forced to 0 while ready_o = 0.
- FSM states: CLEAR, RUN.
  - CLEAR: each cycle writes 0 to regs[counter], then counter increments.
  - When counter = REG_NUM-1 is written, go to RUN; ready_o = 1 from the next cycle.
  - Clear takes exactly REG_NUM-1 cycles after reset deasserts.
  - In CLEAR, wa/wb/alloc requests are ignored.
  - RUN persists until reset.
- Reset mid-CLEAR or mid-RUN: restarts CLEAR from 1 and clears all busy bits; register contents are not otherwise guaranteed until ready_o = 1.
- Register 0:
  - Never written.
  - Always reads 0.
  - Never busy: alloc to 0 ignored, rd_busy_o = 0 for address 0.
- Writes (RUN only): registered on the clk_i rising edge.
  - If wa and wb target the same nonzero address in the same cycle, port B's data is stored.
- Reads, per port k:
  - If rd_re_i[k] = 0: data = 0, busy = 0.
  - Otherwise data = regs[addr]; busy = busy[addr] as currently registered.
- Scoreboard (RUN only), per register r != 0, applied at the clock edge:
  - Set if alloc_we_i and alloc_addr_i = r.
  - Else cleared if (wa_we_i and wa_addr_i = r) or (wb_we_i and wb_addr_i = r).
  - Set wins over clear in the same cycle, because the new producer supersedes.
  - Alloc of an already-busy register keeps it busy.
  - A write to a non-busy register is legal; it stores the data and the bit stays 0.
- Widths: address comparisons use the full REG_AW bits. No arithmetic in the block.

Optional Feature:
- Macro: GPR_BYPASS_EN.
- Defined: same-cycle write-to-read forwarding in RUN.
  - If rd_re_i[k] and addr = a nonzero write address with its enable high, rd_data_o[k] = that write data. Port B has priority over A.
  - rd_busy_o[k] = 0 in that case, unless alloc_we_i also targets the same address that cycle.
- Undefined: no forwarding. Read data shows the written value from the cycle after the write; busy clears the cycle after the write.

Test Plan:
- Reset 1 cycle, then idle, REG_NUM=32 → ready_o = 0 for 31 cycles then 1; all reads of regs 1..31 return 0x00000000.
- In RUN, wa writes 0xDEADBEEF to x5; next cycle port 0 reads x5 → 0xDEADBEEF. A write of 0x1234 to x0 → x0 reads 0.
- Same cycle: wa x7 = 0x11, wb x7 = 0x22 → x7 reads 0x22. With GPR_BYPASS_EN, a same-cycle read of x7 returns 0x22.
- Alloc x9 → rd_busy_o = 1 next cycle. Write x9 and alloc x9 in the same cycle → still busy. Next cycle write only → busy = 0 after that edge.
- Write x3 = 0xAA in RUN; assert rst_i for 1 cycle mid-sequence → busy bits 0, ready_o = 0 for 31 cycles, x3 reads 0 after ready_o rises.
- NRP=3: ports read x1, x2, x1 with rd_re_i = 3'b101 → port 1 returns 0 and not busy; ports 0 and 2 return x1's value.
